// File: rtl/spi_cmd_pkg.sv
// -----------------------------------------------------------------------------
// spi_cmd_pkg
// Shared definitions for the SPI command master: frame geometry, the FSM
// state encoding and a helper that builds the 40-bit outgoing frame.
// -----------------------------------------------------------------------------
package spi_cmd_pkg;

  localparam int ADR_W      = 8;
  localparam int DATA_W     = 32;
  localparam int FRAME_BITS = ADR_W + DATA_W;  // 40

  // Index of the first bit shifted out; the bit counter starts here.
  localparam logic [5:0] LAST_BIT = 6'd39;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } state_e;

  // Address goes out first, then the payload, both MSB first.
  function automatic logic [FRAME_BITS-1:0] pack_frame(
    input logic [ADR_W-1:0]  adr,
    input logic [DATA_W-1:0] data
  );
    return {adr, data};
  endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// -----------------------------------------------------------------------------
// spi_tick_gen
// Half-period enable generator. While en_i is high, tick_o pulses once every
// CLK_DIV clock cycles (on the last cycle of each half-period). Dropping en_i
// restarts the count so every phase begins with a full half-period.
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset
//   en_i   : count enable / restart when low
//   tick_o : one-cycle pulse at the end of each CLK_DIV-cycle window
// -----------------------------------------------------------------------------
module spi_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  output logic tick_o
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // Next count: hold at zero while disabled, wrap after the last cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (!en_i) begin
      cnt_d = 8'd0;
    end else if (cnt_q == DIV_LAST) begin
      cnt_d = 8'd0;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = en_i && (cnt_q == DIV_LAST);

endmodule

// File: rtl/spi_cmd_master.sv
// -----------------------------------------------------------------------------
// spi_cmd_master
// Mode-0 SPI master issuing 40-bit register frames (8-bit address followed by
// a 32-bit payload). The last 32 MISO bits of each frame are returned on
// rsp_rdata with a one-cycle rsp_valid pulse when xCS rises.
//   clk_125   : sole clock          srstb     : async active-low reset
//   cmd_valid/cmd_ready : command handshake
//   cmd_rd, cmd_adr, cmd_wdata : command fields, captured on acceptance
//   rsp_valid, rsp_rdata : frame-end pulse and captured data
//   xCS, xSCK, xMOSI, xMISO : SPI pins (xCS active low, xSCK idles low)
// -----------------------------------------------------------------------------
module spi_cmd_master #(
  parameter int CLK_DIV = 4,
  parameter int GAP_CYC = 8
) (
  input  logic        clk_125,
  input  logic        srstb,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_rd,
  input  logic [7:0]  cmd_adr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        xCS,
  output logic        xSCK,
  output logic        xMOSI,
  input  logic        xMISO
);

  import spi_cmd_pkg::*;

  // The IDLE cycle in which cmd_ready is high counts toward the xCS-high gap,
  // so GAP itself lasts one cycle less; it never drops below one cycle since
  // rsp_valid is issued from it.
  localparam int         GAP_LEN  = (GAP_CYC > 1) ? (GAP_CYC - 1) : 1;
  localparam logic [7:0] GAP_LAST = 8'(GAP_LEN - 1);

  state_e                 state_q, state_d;
  logic [FRAME_BITS-1:0]  tx_q, tx_d;
  logic [DATA_W-1:0]      rx_q, rx_d;
  logic [DATA_W-1:0]      rdata_q, rdata_d;
  logic [5:0]             bit_q, bit_d;
  logic [7:0]             gap_q, gap_d;
  logic                   sck_q, sck_d;
  logic                   cs_q, cs_d;
  logic                   ready_q, ready_d;
  logic                   rv_q, rv_d;
  logic                   rd_q, rd_d;
  logic                   tick_s;
  logic                   tick_en_s;
  logic                   unused_rd_s;

  // Frame direction is latched with the command; the wire format is the same
  // for reads and writes, so it has no further consumer.
  assign unused_rd_s = rd_q;

  assign tick_en_s = (state_q == ST_SETUP) || (state_q == ST_SHIFT) ||
                     (state_q == ST_HOLD);

  spi_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk_i  (clk_125),
    .rst_ni (srstb),
    .en_i   (tick_en_s),
    .tick_o (tick_s)
  );

  // Frame sequencer: next state, pin values and shift registers.
  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rdata_d = rdata_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    sck_d   = sck_q;
    cs_d    = cs_q;
    rd_d    = rd_q;
    rv_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && ready_q) begin
          state_d = ST_SETUP;
          tx_d    = pack_frame(cmd_adr, cmd_wdata);
          rd_d    = cmd_rd;
          bit_d   = LAST_BIT;
          cs_d    = 1'b0;
          sck_d   = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        // First rising edge; MISO is captured on the edge that raises xSCK.
        if (tick_s) begin
          state_d = ST_SHIFT;
          sck_d   = 1'b1;
          rx_d    = {rx_q[DATA_W-2:0], xMISO};
        end else begin
          state_d = ST_SETUP;
        end
      end
      ST_SHIFT: begin
        // bit_q names the bit being clocked; it steps down on each rising
        // edge, so it stops at zero instead of wrapping.
        if (!tick_s) begin
          state_d = ST_SHIFT;
        end else if (sck_q) begin
          sck_d = 1'b0;
          if (bit_q != 6'd0) begin
            tx_d = {tx_q[FRAME_BITS-2:0], 1'b0};
          end else begin
            tx_d = tx_q;
          end
        end else if (bit_q == 6'd0) begin
          state_d = ST_HOLD;
        end else begin
          sck_d = 1'b1;
          bit_d = bit_q - 6'd1;
          rx_d  = {rx_q[DATA_W-2:0], xMISO};
        end
      end
      ST_HOLD: begin
        if (tick_s) begin
          state_d = ST_GAP;
          cs_d    = 1'b1;
          tx_d    = '0;
          rv_d    = 1'b1;
          rdata_d = rx_q;
          gap_d   = 8'd0;
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cs_d    = 1'b1;
        sck_d   = 1'b0;
        tx_d    = '0;
      end
    endcase

    // Registered so that cmd_ready is high exactly while the FSM sits in IDLE.
    ready_d = (state_d == ST_IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk_125 or negedge srstb) begin
    if (!srstb) begin
      state_q <= ST_IDLE;
      tx_q    <= '0;
      rx_q    <= '0;
      rdata_q <= '0;
      bit_q   <= 6'd0;
      gap_q   <= 8'd0;
      sck_q   <= 1'b0;
      cs_q    <= 1'b1;
      ready_q <= 1'b0;
      rv_q    <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      sck_q   <= sck_d;
      cs_q    <= cs_d;
      ready_q <= ready_d;
      rv_q    <= rv_d;
      rd_q    <= rd_d;
    end
  end

  assign cmd_ready = ready_q;
  assign rsp_valid = rv_q;
  assign rsp_rdata = rdata_q;
  assign xCS       = cs_q;
  assign xSCK      = sck_q;
  // tx_q is cleared whenever xCS is high, so xMOSI idles low.
  assign xMOSI     = tx_q[FRAME_BITS-1];

endmodule

// File: tb/tb_spi_cmd_master.sv
// -----------------------------------------------------------------------------
// tb_spi_cmd_master
// Directed bench for spi_cmd_master: a CLK_DIV=4 instance driven by a small
// SPI slave model, and a CLK_DIV=2 instance for clock-shape checks.
// -----------------------------------------------------------------------------
module tb_spi_cmd_master;

  logic        clk = 1'b0;
  logic        srstb;
  logic        cmd_valid, cmd_ready, cmd_rd;
  logic [7:0]  cmd_adr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        cs, sck, mosi, miso;

  logic        cmd_valid2, cmd_ready2;
  logic [7:0]  cmd_adr2;
  logic [31:0] cmd_wdata2;
  logic        rsp_valid2;
  logic [31:0] rsp_rdata2;
  logic        cs2, sck2, mosi2;

  int checks   = 0;
  int failures = 0;

  always #4 clk = ~clk;

  spi_cmd_master #(.CLK_DIV(4), .GAP_CYC(8)) dut (
    .clk_125(clk), .srstb(srstb), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rd(cmd_rd), .cmd_adr(cmd_adr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .xCS(cs), .xSCK(sck), .xMOSI(mosi), .xMISO(miso)
  );

  spi_cmd_master #(.CLK_DIV(2), .GAP_CYC(8)) dut2 (
    .clk_125(clk), .srstb(srstb), .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
    .cmd_rd(1'b0), .cmd_adr(cmd_adr2), .cmd_wdata(cmd_wdata2),
    .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2),
    .xCS(cs2), .xSCK(sck2), .xMOSI(mosi2), .xMISO(1'b1)
  );

  // ---------------- slave model / monitor for dut ----------------
  logic [39:0] slave_ret   = 40'h0;
  logic [39:0] mosi_frame  = 40'h0;
  int          rise_cnt    = 40;
  int          low_cnt     = 0;
  int          high_cnt    = 0;
  int          last_low    = 0;
  int          last_high   = 0;
  int          rv_cnt      = 0;
  int          ready_cnt   = 0;
  int          idle_err    = 0;
  logic [31:0] rv_data     = 32'h0;
  logic        prev_cs     = 1'b1;
  logic        prev_sck    = 1'b0;

  // Slave presents the next return bit after each rising edge it sees.
  always_comb begin
    miso = 1'b0;
    if (rise_cnt < 40) miso = slave_ret[39 - rise_cnt];
  end

  always @(negedge clk) begin
    if (cs) begin
      if (!prev_cs) begin
        last_low = low_cnt;
        high_cnt = 0;
      end
      high_cnt++;
      if (sck || mosi) idle_err++;
    end else begin
      if (prev_cs) begin
        last_high  = high_cnt;
        low_cnt    = 0;
        rise_cnt   = 0;
        mosi_frame = 40'h0;
      end
      low_cnt++;
      if (sck && !prev_sck) begin
        mosi_frame = {mosi_frame[38:0], mosi};
        rise_cnt++;
      end
    end
    if (rsp_valid) begin
      rv_cnt++;
      rv_data = rsp_rdata;
    end
    if (cmd_ready) ready_cnt++;
    prev_cs  = cs;
    prev_sck = sck;
  end

  // ---------------- monitor for dut2 ----------------
  logic [39:0] frame2    = 40'h0;
  int          rise2     = 0;
  int          low2      = 0;
  int          since2    = 0;
  int          min_per2  = 999;
  int          max_per2  = 0;
  int          unstable2 = 0;
  logic        pcs2      = 1'b1;
  logic        psck2     = 1'b0;
  logic        pmosi2    = 1'b0;

  always @(negedge clk) begin
    if (!cs2) begin
      if (pcs2) begin
        rise2 = 0; low2 = 0; since2 = 0; frame2 = 40'h0;
        min_per2 = 999; max_per2 = 0; unstable2 = 0;
      end
      low2++;
      since2++;
      if (sck2 && !psck2) begin
        if (rise2 > 0) begin
          if (since2 < min_per2) min_per2 = since2;
          if (since2 > max_per2) max_per2 = since2;
        end
        since2 = 0;
        rise2++;
        frame2 = {frame2[38:0], mosi2};
        if (mosi2 !== pmosi2) unstable2++;
      end
    end
    pcs2   = cs2;
    psck2  = sck2;
    pmosi2 = mosi2;
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits for the handshake on dut and returns 1 ns after the accepting edge.
  task automatic accept_wait(input string tag);
    int n = 0;
    while (n < 2000) begin
      @(negedge clk);
      if (cmd_valid && cmd_ready) break;
      n++;
    end
    check(tag, 64'(n < 2000), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(input string tag, input int target);
    int n = 0;
    while (n < 3000 && rv_cnt < target) begin
      @(negedge clk);
      #1;
      n++;
    end
    check(tag, 64'(rv_cnt >= target), 64'd1);
  endtask

  task automatic send(input logic rd, input logic [7:0] adr, input logic [31:0] wd,
                      input string tag);
    cmd_rd = rd; cmd_adr = adr; cmd_wdata = wd; cmd_valid = 1'b1;
    accept_wait(tag);
    cmd_valid = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int base_rv;
    int base_ready;
    int n;

    srstb = 1'b0; cmd_valid = 1'b0; cmd_rd = 1'b0; cmd_adr = 8'h0; cmd_wdata = 32'h0;
    cmd_valid2 = 1'b0; cmd_adr2 = 8'h0; cmd_wdata2 = 32'h0;

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_cs", 64'(cs), 64'd1);
    check("rst_sck", 64'(sck), 64'd0);
    check("rst_mosi", 64'(mosi), 64'd0);
    check("rst_ready", 64'(cmd_ready), 64'd0);
    check("rst_rv", 64'(rsp_valid), 64'd0);
    check("rst_rdata", 64'(rsp_rdata), 64'd0);

    // cmd_ready rises on the first edge after release.
    @(posedge clk); #1; srstb = 1'b1;
    @(posedge clk); #1;
    check("ready_after_rst", 64'(cmd_ready), 64'd1);

    // Write adr 44 / 0xDEADBEEF; slave returns CAFEF00D in the data phase.
    slave_ret = {8'h3C, 32'hCAFEF00D};
    base_rv = rv_cnt;
    send(1'b0, 8'd44, 32'hDEADBEEF, "wr_accept");
    wait_rsp("wr_rsp_timeout", base_rv + 1);
    check("wr_frame", 64'(mosi_frame), {24'h0, 8'h2C, 32'hDEADBEEF});
    check("wr_cs_low", 64'(last_low), 64'd328);
    check("wr_rises", 64'(rise_cnt), 64'd40);
    check("wr_rdata", 64'(rv_data), 64'hCAFEF00D);
    repeat (20) @(posedge clk); #1;
    check("wr_one_pulse", 64'(rv_cnt - base_rv), 64'd1);

    // Read adr 18, slave returns 0x12345678.
    slave_ret = {8'hA5, 32'h12345678};
    base_rv = rv_cnt;
    send(1'b1, 8'd18, 32'h0000_0000, "rd_accept");
    wait_rsp("rd_rsp_timeout", base_rv + 1);
    check("rd_rdata_at_valid", 64'(rv_data), 64'h12345678);
    check("rd_frame", 64'(mosi_frame), {24'h0, 8'h12, 32'h0});
    repeat (30) @(posedge clk); #1;
    check("rd_rdata_hold", 64'(rsp_rdata), 64'h12345678);

    // Three commands with cmd_valid held high.
    slave_ret = 40'h0;
    base_rv = rv_cnt;
    cmd_rd = 1'b0; cmd_adr = 8'h01; cmd_wdata = 32'h11111111; cmd_valid = 1'b1;
    accept_wait("b2b_acc0");
    base_ready = ready_cnt;
    cmd_adr = 8'h02; cmd_wdata = 32'h22222222;
    accept_wait("b2b_acc1");
    cmd_adr = 8'h03; cmd_wdata = 32'h33333333;
    @(negedge clk); #1;
    check("b2b_gap1", 64'(last_high), 64'd8);
    accept_wait("b2b_acc2");
    cmd_valid = 1'b0;
    @(negedge clk); #1;
    check("b2b_gap2", 64'(last_high), 64'd8);
    check("b2b_ready_cycles", 64'(ready_cnt - base_ready), 64'd2);
    wait_rsp("b2b_rsp_timeout", base_rv + 3);
    check("b2b_frame3", 64'(mosi_frame), {24'h0, 8'h03, 32'h33333333});

    // Inputs changed right after acceptance must not alter the frame.
    base_rv = rv_cnt;
    send(1'b0, 8'h5A, 32'h01020304, "chg_accept");
    cmd_adr = 8'hFF; cmd_wdata = 32'h0;
    wait_rsp("chg_rsp_timeout", base_rv + 1);
    check("chg_frame", 64'(mosi_frame), {24'h0, 8'h5A, 32'h01020304});

    // Reset asserted mid-frame around bit 20.
    base_rv = rv_cnt;
    send(1'b0, 8'hC3, 32'hA5A5A5A5, "abort_accept");
    n = 0;
    while (n < 2000 && rise_cnt < 20) begin
      @(negedge clk); #1; n++;
    end
    check("abort_reach_bit20", 64'(rise_cnt >= 20), 64'd1);
    srstb = 1'b0;
    #1;
    check("abort_cs", 64'(cs), 64'd1);
    check("abort_sck", 64'(sck), 64'd0);
    check("abort_mosi", 64'(mosi), 64'd0);
    check("abort_rdata", 64'(rsp_rdata), 64'd0);
    repeat (20) @(posedge clk); #1;
    check("abort_no_rv", 64'(rv_cnt - base_rv), 64'd0);
    srstb = 1'b1;
    repeat (2) @(posedge clk); #1;
    base_rv = rv_cnt;
    send(1'b0, 8'h81, 32'h0F0F0F0F, "post_abort_accept");
    wait_rsp("post_abort_rsp_timeout", base_rv + 1);
    check("post_abort_frame", 64'(mosi_frame), {24'h0, 8'h81, 32'h0F0F0F0F});
    check("post_abort_rises", 64'(rise_cnt), 64'd40);
    check("post_abort_cs_low", 64'(last_low), 64'd328);

    // CLK_DIV=2 instance: clock shape and MOSI stability.
    cmd_adr2 = 8'h96; cmd_wdata2 = 32'h0BADF00D; cmd_valid2 = 1'b1;
    n = 0;
    while (n < 2000) begin
      @(negedge clk);
      if (cmd_ready2) break;
      n++;
    end
    check("div2_accept", 64'(n < 2000), 64'd1);
    @(posedge clk); #1;
    cmd_valid2 = 1'b0;
    n = 0;
    while (n < 2000) begin
      @(negedge clk);
      if (rsp_valid2) break;
      n++;
    end
    check("div2_rsp", 64'(n < 2000), 64'd1);
    #1;
    check("div2_rises", 64'(rise2), 64'd40);
    check("div2_min_period", 64'(min_per2), 64'd4);
    check("div2_max_period", 64'(max_per2), 64'd4);
    check("div2_mosi_stable", 64'(unstable2), 64'd0);
    check("div2_frame", 64'(frame2), {24'h0, 8'h96, 32'h0BADF00D});
    check("div2_cs_low", 64'(low2), 64'd164);
    check("div2_rdata", 64'(rsp_rdata2), 64'hFFFFFFFF);

    // xSCK / xMOSI never active while xCS is high (whole run).
    check("idle_pins_low", 64'(idle_err), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_cmd_master.md
SPI_CMD_MASTER -- requirements
Module: spi_cmd_master

Interface
REQ-001 Parameter CLK_DIV, default 4: SCK half-period in clk_125 cycles; legal range 2..255.
REQ-002 Parameter GAP_CYC, default 8: minimum xCS high time between frames, in clk_125 cycles; legal range 1..255.
REQ-003 clk_125  in  1  sole clock.
REQ-004 srstb  in  1  reset; asynchronous assertion, active-low.
REQ-005 cmd_valid  in  1  command request.
REQ-006 cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high on a clk_125 edge.
REQ-007 cmd_rd  in  1  1 = read frame, 0 = write frame.
REQ-008 cmd_adr  in  8  register address (e.g. 44 = CRC MEM3, 18 = mem1 status).
REQ-009 cmd_wdata  in  32  write payload; shifted out on read frames as well.
REQ-010 rsp_valid  out  1  one-cycle pulse at frame end.
REQ-011 rsp_rdata  out  32  the 32 MISO bits sampled during the data phase; valid while rsp_valid is high.
REQ-012 xCS  out  1  chip select, active low.
REQ-013 xSCK  out  1  SPI clock, mode 0 (idles low).
REQ-014 xMOSI  out  1  serial data out, MSB first.
REQ-015 xMISO  in  1  serial data in.

Function
REQ-016 The frame SHALL be 40 bits: cmd_adr[7:0] first, then cmd_wdata[31:0], both MSB first.
REQ-017 cmd_ready SHALL be high only in IDLE, so at most one command is in flight.
REQ-018 cmd_rd, cmd_adr and cmd_wdata SHALL be registered on acceptance; input changes after acceptance SHALL have no effect.
REQ-019 States and transitions:
- IDLE->SETUP on accept.
- SETUP (CLK_DIV cycles)->SHIFT.
- SHIFT (80*CLK_DIV cycles)->HOLD.
- HOLD (CLK_DIV cycles)->GAP.
- GAP (GAP_CYC cycles)->IDLE.
REQ-020 xCS SHALL go low on the cycle after acceptance and stay low through SETUP, SHIFT and HOLD; it SHALL go high on entry to GAP.
REQ-021 xMOSI SHALL present bit 39 from the cycle xCS falls.
REQ-022 In SHIFT, each bit SHALL drive xSCK high for CLK_DIV cycles, then low for CLK_DIV cycles.
REQ-023 xMOSI SHALL advance to the next bit on each xSCK falling edge, except after bit 0.
REQ-024 xMISO SHALL be sampled on the clk_125 cycle on which xSCK rises.
REQ-025 Only the last 32 xMISO samples SHALL form rsp_rdata; the 8 samples taken during the address phase SHALL be discarded.
REQ-026 rsp_valid SHALL pulse on the GAP-entry cycle for both read and write frames.
REQ-027 On write frames rsp_rdata SHALL still carry the captured bits.
REQ-028 rsp_rdata SHALL hold its value until the next rsp_valid.
REQ-029 The bit counter SHALL be 6 bits, count 39 down to 0, and never wrap.
REQ-030 A cmd_valid held high during GAP SHALL be accepted on the first IDLE cycle, so frames run back-to-back with exactly GAP_CYC cycles of xCS high.
REQ-031 xSCK and xMOSI SHALL be low whenever xCS is high.

Reset
REQ-032 While srstb is low, outputs SHALL immediately be: xCS=1, xSCK=0, xMOSI=0, cmd_ready=0, rsp_valid=0, rsp_rdata=0.
REQ-033 While srstb is low, the state SHALL be IDLE.
REQ-034 Reset assertion mid-frame SHALL abort the frame with no rsp_valid.
REQ-035 After srstb deasserts, cmd_ready SHALL rise on the first clk_125 edge.

Structure
REQ-036 Package spi_cmd_pkg SHALL hold the state enum, ADR_W=8, DATA_W=32 and FRAME_BITS=40.
REQ-037 Sub-module spi_tick_gen SHALL generate the CLK_DIV half-period enable.
REQ-038 The FSM, shift registers and counters SHALL live in spi_cmd_master.

Verification
REQ-039 Write adr 44, data 0xDEADBEEF, CLK_DIV=4 -> bench SPI slave decodes 0x2C/0xDEADBEEF; xCS low for exactly 328 cycles; rsp_valid one pulse.
REQ-040 Read adr 18, slave returns 0x12345678 in the data phase -> rsp_rdata=0x12345678 with rsp_valid.
REQ-041 cmd_valid held high for 3 commands, GAP_CYC=8 -> three frames, each xCS-high gap exactly 8 cycles, cmd_ready high 1 cycle per frame.
REQ-042 cmd_adr/cmd_wdata changed to 0xFF/0 one cycle after accept -> the frame still carries the original values.
REQ-043 srstb low at bit 20 -> xCS=1, xSCK=0 with no clock edge; no rsp_valid; next command produces a clean 40-bit frame.
REQ-044 CLK_DIV=2 -> xSCK period of 4 cycles; 40 rising edges per frame; MOSI stable for 2 cycles around each rising edge.
